// File: rtl/nco_phase_gen_if.sv
// Control/status bundle between the NCO phase generator and its host.
// Signal names keep the block's _i/_o suffixes as seen from the NCO.
interface nco_phase_gen_if #(
  parameter int PHASE_W = 32,
  parameter int RATE_W  = 16
);
  logic               enable_i;
  logic [RATE_W-1:0]  rate_div_i;
  logic [PHASE_W-1:0] ftw_i;
  logic               ftw_load_i;
  logic [PHASE_W-1:0] poff_i;
  logic               sync_i;
  logic               chirp_en_i;
  logic [PHASE_W-1:0] chirp_step_i;
  logic [PHASE_W-1:0] chirp_stop_i;
  logic [PHASE_W-1:0] phase_o;
  logic               valid_o;
  logic [PHASE_W-1:0] ftw_o;
  logic               chirp_done_o;

  modport master (
    output enable_i, rate_div_i, ftw_i, ftw_load_i, poff_i, sync_i,
           chirp_en_i, chirp_step_i, chirp_stop_i,
    input  phase_o, valid_o, ftw_o, chirp_done_o
  );

  modport slave (
    input  enable_i, rate_div_i, ftw_i, ftw_load_i, poff_i, sync_i,
           chirp_en_i, chirp_step_i, chirp_stop_i,
    output phase_o, valid_o, ftw_o, chirp_done_o
  );
endinterface

// File: rtl/nco_phase_gen.sv
// Phase accumulator with output-rate divider, phase-continuous FTW updates,
// phase offset, resync and linear FTW sweep, feeding the CORDIC phase input.
module nco_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int RATE_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  nco_phase_gen_if.slave bus
);
  typedef enum logic [1:0] {RUN, SWEEP, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [RATE_W-1:0]  r_count, w_count_nxt;
  logic [PHASE_W-1:0] r_acc, w_acc_nxt;
  logic [PHASE_W-1:0] r_shadow, w_shadow_nxt;
  logic [PHASE_W-1:0] r_ftw, w_ftw_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic               r_pending, w_pending_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_done, w_done_nxt;

  logic               w_tick;
  logic [PHASE_W:0]   w_sum;
  logic               w_step_neg, w_step_pos, w_stop_hit;

  // Resync suppresses a tick that would otherwise be due this cycle.
  assign w_tick = bus.enable_i && !bus.sync_i && (r_count == bus.rate_div_i);

  // Bit PHASE_W of the sign-extended sum flags carry-out (up) or borrow (down).
  assign w_sum      = {1'b0, r_ftw} + {bus.chirp_step_i[PHASE_W-1], bus.chirp_step_i};
  assign w_step_neg = bus.chirp_step_i[PHASE_W-1];
  assign w_step_pos = !w_step_neg && (|bus.chirp_step_i);
  assign w_stop_hit = w_step_pos ? (w_sum[PHASE_W] || (w_sum[PHASE_W-1:0] >= bus.chirp_stop_i))
                    : w_step_neg ? (w_sum[PHASE_W] || (w_sum[PHASE_W-1:0] <= bus.chirp_stop_i))
                    : 1'b0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_acc_nxt     = r_acc;
    w_shadow_nxt  = r_shadow;
    w_ftw_nxt     = r_ftw;
    w_phase_nxt   = r_phase;
    w_pending_nxt = r_pending;
    w_valid_nxt   = w_tick;
    w_done_nxt    = r_done;

    if (bus.sync_i || !bus.enable_i || w_tick) w_count_nxt = '0;
    else                                       w_count_nxt = r_count + 1'b1;

    if (bus.sync_i) begin
      w_acc_nxt = '0;
    end else if (w_tick) begin
      w_phase_nxt = r_acc + bus.poff_i;
      w_acc_nxt   = r_acc + r_ftw;
    end

    // Only a load already pending before this edge may apply; a same-edge load waits.
    if (w_tick && (r_state == RUN) && r_pending) begin
      w_ftw_nxt     = r_shadow;
      w_pending_nxt = 1'b0;
    end
    if (bus.ftw_load_i) begin
      w_shadow_nxt  = bus.ftw_i;
      w_pending_nxt = 1'b1;
    end

    unique case (r_state)
      RUN: begin
        if (bus.chirp_en_i) w_state_nxt = SWEEP;
      end
      SWEEP: begin
        if (w_tick) begin
          if (w_stop_hit) begin
            w_ftw_nxt   = bus.chirp_stop_i;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_ftw_nxt = w_sum[PHASE_W-1:0];
          end
        end
        if (!bus.chirp_en_i) begin
          w_state_nxt = RUN;
          w_done_nxt  = 1'b0;
        end
      end
      DONE: begin
        if (!bus.chirp_en_i) begin
          w_state_nxt = RUN;
          w_done_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= RUN;
      r_count   <= '0;
      r_acc     <= '0;
      r_shadow  <= '0;
      r_ftw     <= '0;
      r_phase   <= '0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_acc     <= w_acc_nxt;
      r_shadow  <= w_shadow_nxt;
      r_ftw     <= w_ftw_nxt;
      r_phase   <= w_phase_nxt;
      r_pending <= w_pending_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.phase_o      = r_phase;
  assign bus.valid_o      = r_valid;
  assign bus.ftw_o        = r_ftw;
  assign bus.chirp_done_o = r_done;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen: stepping, divider, FTW load,
// resync with offset, up/down sweep and mid-run reset.
module tb_nco_phase_gen;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  nco_phase_gen_if #(.PHASE_W(32), .RATE_W(16)) bus ();

  nco_phase_gen #(.PHASE_W(32), .RATE_W(16)) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards apply at the next edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (bus.valid_o) break;
    end
    check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd1);
  endtask

  // Make v the active FTW with the accumulator cleared and divider at 0.
  task automatic prime(input logic [31:0] v);
    bus.ftw_i = v; bus.ftw_load_i = 1'b1; bus.enable_i = 1'b0; bus.rate_div_i = '0;
    step();
    bus.ftw_load_i = 1'b0; bus.enable_i = 1'b1;
    step();
    bus.enable_i = 1'b0; bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
  endtask

  int n;
  logic [31:0] exp_phase [5] = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
  logic [31:0] up_ftw    [4] = '{32'h0180_0000, 32'h0200_0000, 32'h0280_0000, 32'h0300_0000};
  logic [31:0] dn_ftw    [4] = '{32'h0280_0000, 32'h0200_0000, 32'h0180_0000, 32'h0150_0000};

  initial begin
    bus.enable_i = 1'b0; bus.rate_div_i = '0; bus.ftw_i = '0; bus.ftw_load_i = 1'b0;
    bus.poff_i = '0; bus.sync_i = 1'b0; bus.chirp_en_i = 1'b0;
    bus.chirp_step_i = '0; bus.chirp_stop_i = '0;

    step(); step();
    check("rst_phase", bus.phase_o, 32'h0);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_ftw",   bus.ftw_o, 32'h0);
    check("rst_done",  {31'd0, bus.chirp_done_o}, 32'd0);
    rst_ni = 1'b1;

    // Basic stepping with wrap, strobe every cycle.
    prime(32'h4000_0000);
    bus.enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t1_valid%0d", i), {31'd0, bus.valid_o}, 32'd1);
      check($sformatf("t1_phase%0d", i), bus.phase_o, exp_phase[i]);
    end

    // Divider of 4 and enable freeze.
    prime(32'h1000_0000);
    bus.rate_div_i = 16'd3; bus.enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t2", n);
      check($sformatf("t2_gap%0d", i), n, 32'd4);
      check($sformatf("t2_phase%0d", i), bus.phase_o, 32'h1000_0000 * i);
    end
    bus.enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t2_frozen%0d", i), {31'd0, bus.valid_o}, 32'd0);
    end
    bus.enable_i = 1'b1;
    wait_valid("t2r", n);
    check("t2_resume_gap", n, 32'd4);
    check("t2_resume_phase", bus.phase_o, 32'h3000_0000);

    // Phase-continuous FTW load between the first and second ticks.
    prime(32'h1000_0000);
    bus.rate_div_i = 16'd1; bus.enable_i = 1'b1; bus.poff_i = '0;
    wait_valid("t3a", n);
    check("t3_phase0", bus.phase_o, 32'h0);
    bus.ftw_i = 32'h2000_0000; bus.ftw_load_i = 1'b1;
    step();
    bus.ftw_load_i = 1'b0;
    check("t3_noload_valid", {31'd0, bus.valid_o}, 32'd0);
    check("t3_ftw_old", bus.ftw_o, 32'h1000_0000);
    step();
    check("t3_phase1", bus.phase_o, 32'h1000_0000);
    check("t3_ftw_new", bus.ftw_o, 32'h2000_0000);
    wait_valid("t3b", n);
    check("t3_phase2", bus.phase_o, 32'h2000_0000);
    wait_valid("t3c", n);
    check("t3_phase3", bus.phase_o, 32'h4000_0000);

    // Resync with phase offset.
    bus.poff_i = 32'h0800_0000; bus.rate_div_i = '0;
    step();
    check("t4_pre_phase", bus.phase_o, 32'h6800_0000);
    bus.sync_i = 1'b1;
    step();
    bus.sync_i = 1'b0;
    check("t4_sync_valid", {31'd0, bus.valid_o}, 32'd0);
    step();
    check("t4_phase0", bus.phase_o, 32'h0800_0000);
    step();
    check("t4_phase1", bus.phase_o, 32'h2800_0000);

    // Sweep up.
    prime(32'h0100_0000);
    bus.chirp_step_i = 32'h0080_0000; bus.chirp_stop_i = 32'h0300_0000;
    bus.chirp_en_i = 1'b1; bus.enable_i = 1'b1;
    step();
    check("t5_enter_ftw", bus.ftw_o, 32'h0100_0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_up_ftw%0d", i), bus.ftw_o, up_ftw[i]);
      check($sformatf("t5_up_done%0d", i), {31'd0, bus.chirp_done_o}, (i == 3) ? 32'd1 : 32'd0);
    end
    step();
    check("t5_up_hold", bus.ftw_o, 32'h0300_0000);
    check("t5_up_done_sticky", {31'd0, bus.chirp_done_o}, 32'd1);
    bus.chirp_en_i = 1'b0;
    step();
    check("t5_up_clear", {31'd0, bus.chirp_done_o}, 32'd0);

    // Sweep down with clamp.
    bus.chirp_step_i = 32'hFF80_0000; bus.chirp_stop_i = 32'h0150_0000; bus.chirp_en_i = 1'b1;
    step();
    check("t5_dn_enter", bus.ftw_o, 32'h0300_0000);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5_dn_ftw%0d", i), bus.ftw_o, dn_ftw[i]);
    end
    check("t5_dn_done", {31'd0, bus.chirp_done_o}, 32'd1);
    bus.chirp_en_i = 1'b0;
    step();
    check("t5_dn_clear", {31'd0, bus.chirp_done_o}, 32'd0);
    check("t5_dn_kept", bus.ftw_o, 32'h0150_0000);

    // Reset during a sweep.
    bus.chirp_step_i = 32'h0080_0000; bus.chirp_stop_i = 32'h0300_0000; bus.chirp_en_i = 1'b1;
    step(); step();
    check("t6_sweeping", bus.ftw_o, 32'h01D0_0000);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1; bus.chirp_en_i = 1'b0; bus.enable_i = 1'b0;
    check("t6_phase", bus.phase_o, 32'h0);
    check("t6_valid", {31'd0, bus.valid_o}, 32'd0);
    check("t6_ftw",   bus.ftw_o, 32'h0);
    check("t6_done",  {31'd0, bus.chirp_done_o}, 32'd0);
    bus.poff_i = 32'h0800_0000; bus.ftw_i = 32'h4000_0000; bus.ftw_load_i = 1'b1;
    step();
    check("t6_post_valid", {31'd0, bus.valid_o}, 32'd0);
    bus.ftw_load_i = 1'b0; bus.enable_i = 1'b1;
    step();
    check("t6_first_phase", bus.phase_o, 32'h0800_0000);
    check("t6_ftw_applied", bus.ftw_o, 32'h4000_0000);
    step();
    check("t6_second_phase", bus.phase_o, 32'h0800_0000);
    step();
    check("t6_third_phase", bus.phase_o, 32'h4800_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
